// File: rtl/pattern_drive_seq.sv
// Pattern drive sequencer: turns a pwm phase request into registered p/n/tweak drive words
// from a packed field buffer. Define PATTERN_DEADTIME_EN to insert break-before-make dead time.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | disabled, all drives off
// HIGH_DEAD | dead time before high phase (macro build only)
// HIGH      | high-driving phase, P fields applied
// LOW_DEAD  | dead time before low phase (macro build only)
// LOW       | low-driving phase, N fields applied
module pattern_drive_seq #(
    parameter int BUFFER_WIDTH = 8,
    parameter int NO_TWEAKS    = 8,
    parameter int NO_BUFS      = 8,
    parameter int DEAD_CYCLES  = 2,
    localparam int SEL_W       = $clog2(NO_BUFS),
    localparam int NF          = 2 + 2 * (2 + NO_TWEAKS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic                              pwm,
    input  logic [NF*BUFFER_WIDTH-1:0]        field_bus,
    output logic [BUFFER_WIDTH-1:0]           p_drive,
    output logic [BUFFER_WIDTH-1:0]           n_drive,
    output logic [BUFFER_WIDTH-1:0]           tweak_sense,
    output logic [BUFFER_WIDTH-1:0]           tweak_delay,
    output logic [NO_TWEAKS*BUFFER_WIDTH-1:0] tweak_drive,
    output logic [SEL_W-1:0]                  buffer_select,
    output logic [2:0]                        state,
    output logic [15:0]                       edge_count
);

    localparam int F_PDRIVE = 0;
    localparam int F_NDRIVE = 1;
    localparam int F_PSENSE = 2;
    localparam int F_PDELAY = 3;
    localparam int F_PTWEAK = 4;
    localparam int F_NSENSE = 4 + NO_TWEAKS;
    localparam int F_NDELAY = 5 + NO_TWEAKS;
    localparam int F_NTWEAK = 6 + NO_TWEAKS;

    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NO_BUFS - 1);

    if (DEAD_CYCLES < 1 || DEAD_CYCLES > 15) begin : g_dead_range
        $error("DEAD_CYCLES must be in 1..15");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HIGH_DEAD = 3'd1,
        HIGH      = 3'd2,
        LOW_DEAD  = 3'd3,
        LOW       = 3'd4
    } state_t;

    state_t state_q;
    state_t state_nx;
    logic   pwm_q;
    logic   settle_q;
    logic   edge_det;

    logic [BUFFER_WIDTH-1:0]           p_nx;
    logic [BUFFER_WIDTH-1:0]           n_nx;
    logic [BUFFER_WIDTH-1:0]           sense_nx;
    logic [BUFFER_WIDTH-1:0]           delay_nx;
    logic [NO_TWEAKS*BUFFER_WIDTH-1:0] tweak_nx;

`ifdef PATTERN_DEADTIME_EN
    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES - 1);
    logic [3:0] dead_cnt;
`endif

    // settle_q masks the stale pwm_q comparison in the first cycle out of reset
    assign edge_det = (pwm != pwm_q) && !settle_q;
    assign state    = state_q;

    always_comb begin
        state_nx = state_q;
        if (!enable) begin
            state_nx = IDLE;
        end else if (state_q == IDLE || edge_det) begin
`ifdef PATTERN_DEADTIME_EN
            state_nx = pwm ? HIGH_DEAD : LOW_DEAD;
`else
            state_nx = pwm ? HIGH : LOW;
`endif
        end
`ifdef PATTERN_DEADTIME_EN
        else if (state_q == HIGH_DEAD && dead_cnt == 4'd0) begin
            state_nx = HIGH;
        end else if (state_q == LOW_DEAD && dead_cnt == 4'd0) begin
            state_nx = LOW;
        end
`endif
    end

    always_comb begin
        p_nx     = '1;
        n_nx     = '0;
        sense_nx = '0;
        delay_nx = '0;
        tweak_nx = '0;
        if (state_nx == HIGH) begin
            p_nx     = field_bus[F_PDRIVE*BUFFER_WIDTH +: BUFFER_WIDTH];
            sense_nx = field_bus[F_PSENSE*BUFFER_WIDTH +: BUFFER_WIDTH];
            delay_nx = field_bus[F_PDELAY*BUFFER_WIDTH +: BUFFER_WIDTH];
            for (int i = 0; i < NO_TWEAKS; i++) begin
                tweak_nx[i*BUFFER_WIDTH +: BUFFER_WIDTH] =
                    field_bus[(F_PTWEAK+i)*BUFFER_WIDTH +: BUFFER_WIDTH];
            end
        end else if (state_nx == LOW) begin
            n_nx     = field_bus[F_NDRIVE*BUFFER_WIDTH +: BUFFER_WIDTH];
            sense_nx = field_bus[F_NSENSE*BUFFER_WIDTH +: BUFFER_WIDTH];
            delay_nx = field_bus[F_NDELAY*BUFFER_WIDTH +: BUFFER_WIDTH];
            for (int i = 0; i < NO_TWEAKS; i++) begin
                tweak_nx[i*BUFFER_WIDTH +: BUFFER_WIDTH] =
                    field_bus[(F_NTWEAK+i)*BUFFER_WIDTH +: BUFFER_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pwm_q         <= pwm;
            settle_q      <= 1'b1;
            p_drive       <= '1;
            n_drive       <= '0;
            tweak_sense   <= '0;
            tweak_delay   <= '0;
            tweak_drive   <= '0;
            buffer_select <= SEL_MAX;
            edge_count    <= 16'd0;
`ifdef PATTERN_DEADTIME_EN
            dead_cnt      <= 4'd0;
`endif
        end else begin
            state_q     <= state_nx;
            pwm_q       <= pwm;
            settle_q    <= 1'b0;
            p_drive     <= p_nx;
            n_drive     <= n_nx;
            tweak_sense <= sense_nx;
            tweak_delay <= delay_nx;
            tweak_drive <= tweak_nx;

            if (state_nx == IDLE) begin
                buffer_select <= SEL_MAX;
            end else if (edge_det) begin
                buffer_select <= '0;
            end else if (buffer_select != SEL_MAX) begin
                buffer_select <= buffer_select + 1'b1;
            end

            if (enable && edge_det) begin
                edge_count <= edge_count + 16'd1;
            end

`ifdef PATTERN_DEADTIME_EN
            // Reload on any fresh entry into a dead state, including edge restarts
            if ((state_nx == HIGH_DEAD || state_nx == LOW_DEAD) &&
                (state_nx != state_q || edge_det)) begin
                dead_cnt <= DEAD_LOAD;
            end else if (dead_cnt != 4'd0) begin
                dead_cnt <= dead_cnt - 4'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pattern_drive_seq.sv
// Self-checking bench for pattern_drive_seq: directed vector table, hand sequences and a
// randomized run against a phase-level reference model (honours PATTERN_DEADTIME_EN).
module tb_pattern_drive_seq;

    localparam int BW = 8;
    localparam int T  = 8;
    localparam int NB = 8;
    localparam int DC = 2;
    localparam int NF = 2 + 2 * (2 + T);

`ifdef PATTERN_DEADTIME_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              pwm = 1'b1;
    logic [NF*BW-1:0]  field_bus;
    logic [BW-1:0]     fld [NF];
    logic [BW-1:0]     p_drive, n_drive, tweak_sense, tweak_delay;
    logic [T*BW-1:0]   tweak_drive;
    logic [2:0]        buffer_select;
    logic [2:0]        state;
    logic [15:0]       edge_count;

    int n_chk  = 0;
    int n_fail = 0;

    pattern_drive_seq #(
        .BUFFER_WIDTH(BW), .NO_TWEAKS(T), .NO_BUFS(NB), .DEAD_CYCLES(DC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pwm(pwm), .field_bus(field_bus),
        .p_drive(p_drive), .n_drive(n_drive), .tweak_sense(tweak_sense),
        .tweak_delay(tweak_delay), .tweak_drive(tweak_drive),
        .buffer_select(buffer_select), .state(state), .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        field_bus = '0;
        for (int k = 0; k < NF; k++) field_bus[k*BW +: BW] = fld[k];
    end

    // Reference model: phase = high/low/idle plus "cycles already spent in dead time"
    int          m_state;
    int          m_seen;
    int          m_bsel;
    logic        m_q;
    bit          m_first;
    logic [15:0] m_ecnt;
    logic [7:0]  e_p, e_n, e_s, e_d;
    logic [63:0] e_tw;

    task automatic model_update();
        bit edge_e;
        int ns;
        if (!rst_n) begin
            m_state = 0; m_seen = 0; m_q = pwm; m_first = 1; m_bsel = NB - 1; m_ecnt = 0;
        end else begin
            edge_e = (pwm !== m_q) && !m_first;
            if (!enable) ns = 0;
            else if (m_state == 0 || edge_e) begin
                if (pwm) ns = DT ? 1 : 2;
                else     ns = DT ? 3 : 4;
                m_seen = 0;
            end else if (m_state == 1 || m_state == 3) begin
                if (m_seen + 1 >= DC) ns = (m_state == 1) ? 2 : 4;
                else begin ns = m_state; m_seen++; end
            end else ns = m_state;
            if (ns == 0)      m_bsel = NB - 1;
            else if (edge_e)  m_bsel = 0;
            else if (m_bsel < NB - 1) m_bsel++;
            if (edge_e && enable) m_ecnt = m_ecnt + 16'd1;
            m_q = pwm; m_first = 0; m_state = ns;
        end
        e_p = 8'hFF; e_n = 8'h00; e_s = 8'h00; e_d = 8'h00; e_tw = '0;
        if (m_state == 2) begin
            e_p = fld[0]; e_s = fld[2]; e_d = fld[3];
            for (int i = 0; i < T; i++) e_tw[i*8 +: 8] = fld[4+i];
        end else if (m_state == 4) begin
            e_n = fld[1]; e_s = fld[4+T]; e_d = fld[5+T];
            for (int i = 0; i < T; i++) e_tw[i*8 +: 8] = fld[6+T+i];
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("m_state", 64'(state), 64'(m_state));
        chk("m_p_drive", 64'(p_drive), 64'(e_p));
        chk("m_n_drive", 64'(n_drive), 64'(e_n));
        chk("m_sense", 64'(tweak_sense), 64'(e_s));
        chk("m_delay", 64'(tweak_delay), 64'(e_d));
        chk("m_tweak", tweak_drive, e_tw);
        chk("m_bsel", 64'(buffer_select), 64'(m_bsel));
        chk("m_edge_count", 64'(edge_count), 64'(m_ecnt));
    endtask

    task automatic step(input bit do_chk);
        model_update();
        @(posedge clk);
        #1;
        if (do_chk) check_all();
    endtask

    typedef struct {
        bit rst_n; bit en; bit pwm;
        int st; int p; int n; int bsel; int ecnt;
    } vec_t;
    vec_t vecs[$];

    initial begin
        for (int k = 0; k < NF; k++) fld[k] = 8'(k * 7 + 1);
        fld[0]  = 8'h5A;
        fld[1]  = 8'h3C;
        fld[17] = 8'h81;

        vecs.push_back('{0, 0, 1, 0, 'hFF, 'h00, 7, 0});
        vecs.push_back('{0, 0, 1, 0, 'hFF, 'h00, 7, 0});
        if (DT) begin
            vecs.push_back('{1, 1, 1, 1, 'hFF, 'h00, 7, 0});
            vecs.push_back('{1, 1, 1, 1, 'hFF, 'h00, 7, 0});
            vecs.push_back('{1, 1, 1, 2, 'h5A, 'h00, 7, 0});
            vecs.push_back('{1, 1, 0, 3, 'hFF, 'h00, 0, 1});
            vecs.push_back('{1, 1, 1, 1, 'hFF, 'h00, 0, 2});
            for (int i = 1; i <= 12; i++)
                vecs.push_back('{1, 1, 1, (i == 1) ? 1 : 2, (i == 1) ? 'hFF : 'h5A, 'h00,
                                 (i < 7) ? i : 7, 2});
        end else begin
            vecs.push_back('{1, 1, 1, 2, 'h5A, 'h00, 7, 0});
            vecs.push_back('{1, 1, 1, 2, 'h5A, 'h00, 7, 0});
            vecs.push_back('{1, 1, 1, 2, 'h5A, 'h00, 7, 0});
            vecs.push_back('{1, 1, 0, 4, 'hFF, 'h3C, 0, 1});
            vecs.push_back('{1, 1, 1, 2, 'h5A, 'h00, 0, 2});
            for (int i = 1; i <= 12; i++)
                vecs.push_back('{1, 1, 1, 2, 'h5A, 'h00, (i < 7) ? i : 7, 2});
        end
        vecs.push_back('{1, 0, 1, 0, 'hFF, 'h00, 7, 2});

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; enable = vecs[i].en; pwm = vecs[i].pwm;
            step(1);
            chk($sformatf("tbl%0d_state", i), 64'(state), 64'(vecs[i].st));
            chk($sformatf("tbl%0d_p", i), 64'(p_drive), 64'(vecs[i].p));
            chk($sformatf("tbl%0d_n", i), 64'(n_drive), 64'(vecs[i].n));
            chk($sformatf("tbl%0d_bsel", i), 64'(buffer_select), 64'(vecs[i].bsel));
            chk($sformatf("tbl%0d_ecnt", i), 64'(edge_count), 64'(vecs[i].ecnt));
        end

        // Low phase from IDLE, then field tracking
        enable = 1; pwm = 0;
        for (int i = 0; i < DC + 1; i++) step(1);
        chk("low_state", 64'(state), 64'd4);
        chk("low_n", 64'(n_drive), 64'h3C);
        chk("low_p", 64'(p_drive), 64'hFF);
        chk("low_tweak3", 64'(tweak_drive[31:24]), 64'h81);
        chk("low_sense", 64'(tweak_sense), 64'h55);
        chk("low_delay", 64'(tweak_delay), 64'h5C);
        fld[1] = 8'hC3;
        step(1);
        chk("low_track", 64'(n_drive), 64'hC3);

        // Back to high, then reset mid-drive
        pwm = 1;
        for (int i = 0; i < DC + 1; i++) step(1);
        chk("high_state", 64'(state), 64'd2);
        rst_n = 0;
        step(1);
        chk("rst_mid_state", 64'(state), 64'd0);
        chk("rst_mid_p", 64'(p_drive), 64'hFF);
        chk("rst_mid_tweak", tweak_drive, 64'd0);
        chk("rst_mid_ecnt", 64'(edge_count), 64'd0);

        // Randomized run against the model
        for (int c = 0; c < 400; c++) begin
            rst_n  = ($urandom_range(0, 49) != 0);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) pwm = ~pwm;
            if ($urandom_range(0, 7) == 0) fld[$urandom_range(0, NF - 1)] = 8'($urandom);
            step(1);
        end

        // edge_count wrap
        rst_n = 0; step(1);
        rst_n = 1; enable = 1; step(1);
        for (int i = 0; i < 65535; i++) begin
            pwm = ~pwm;
            step(0);
        end
        chk("wrap_pre", 64'(edge_count), 64'hFFFF);
        pwm = ~pwm;
        step(1);
        chk("wrap_post", 64'(edge_count), 64'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
